// File: rtl/fixed_point_booth_multiplier_if.sv
// Operand/result bundle for the fixed-point Booth multiplier.
// The requester drives A, B and start; the multiplier returns result, overflow_flag and finish.
interface fixed_point_booth_multiplier_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             overflow_flag;
  logic             finish;

  modport master (
    output A, B, start,
    input  result, overflow_flag, finish
  );

  modport slave (
    input  A, B, start,
    output result, overflow_flag, finish
  );
endinterface

// File: rtl/fixed_point_booth_multiplier.sv
// Sequential radix-4 Booth multiplier for signed QX.FRAC_BITS operands, one recoding step per cycle.
// Define MULT_SATURATE_EN to clamp result on overflow; otherwise result wraps to the low WIDTH bits.
module fixed_point_booth_multiplier #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 10
) (
  input  logic clk,
  input  logic rst,
  fixed_point_booth_multiplier_if.slave bus
);

  localparam int STEPS = WIDTH / 2;
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        a_reg;
  logic [WIDTH:0]          b_reg;   // B with the implicit B[-1]=0 appended at bit 0
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        step;

  logic signed [WIDTH+1:0] a_ext;
  logic signed [WIDTH+1:0] addend;
  logic signed [WIDTH+1:0] top_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] q;
  logic                    ovf_next;
  logic [WIDTH-1:0]        res_next;

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    a_ext  = {{2{a_reg[WIDTH-1]}}, a_reg};
    addend = '0;
    unique case (b_reg[2:0])
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_ext <<< 1;
      3'b100:         addend = -(a_ext <<< 1);
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase

    // Partial products enter the top WIDTH+2 bits; the shift keeps the running sum exact.
    top_sum  = acc[ACC_W-1:WIDTH] + addend;
    acc_next = $signed({top_sum, acc[WIDTH-1:0]}) >>> 2;

    q        = acc_next >>> FRAC_BITS;
    ovf_next = !((&q[ACC_W-1:WIDTH-1]) || !(|q[ACC_W-1:WIDTH-1]));

`ifdef MULT_SATURATE_EN
    if (ovf_next)
      res_next = q[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_next = q[WIDTH-1:0];
`else
    res_next = q[WIDTH-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      a_reg             <= '0;
      b_reg             <= '0;
      acc               <= '0;
      step              <= '0;
      bus.result        <= '0;
      bus.overflow_flag <= 1'b0;
      bus.finish        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_reg      <= bus.A;
            b_reg      <= {bus.B, 1'b0};
            acc        <= '0;
            step       <= '0;
            bus.finish <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          b_reg <= {{2{b_reg[WIDTH]}}, b_reg[WIDTH:2]};
          step  <= step + 1'b1;
          if (step == CNT_W'(STEPS - 1)) begin
            bus.result        <= res_next;
            bus.overflow_flag <= ovf_next;
            bus.finish        <= 1'b1;
            state             <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_booth_multiplier.sv
// Scoreboard bench for fixed_point_booth_multiplier: driver pushes model results, monitor checks on finish.
// Honours MULT_SATURATE_EN in the reference model the same way the design does.
module tb_fixed_point_booth_multiplier;

  localparam int W = 16;
  localparam int F = 10;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fixed_point_booth_multiplier_if #(.WIDTH(W)) bus ();

  fixed_point_booth_multiplier #(.WIDTH(W), .FRAC_BITS(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic prev_fin = 1'b0;

  logic [W-1:0] last_res;
  logic         last_ovf;
  bit           have_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: exact integer product, floor-shift, range test, then wrap or clamp.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    longint q;
    longint qmax;
    longint qmin;
    p    = longint'($signed(a)) * longint'($signed(b));
    q    = p >>> F;
    qmax = (longint'(1) << (W - 1)) - 1;
    qmin = -(longint'(1) << (W - 1));
    e.ovf = (q > qmax) || (q < qmin);
`ifdef MULT_SATURATE_EN
    if (q > qmax)      e.res = {1'b0, {(W-1){1'b1}}};
    else if (q < qmin) e.res = {1'b1, {(W-1){1'b0}}};
    else               e.res = q[W-1:0];
`else
    e.res = q[W-1:0];
`endif
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every rising finish must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.finish && !prev_fin) begin
      if (sb.size() == 0) begin
        check("spurious_finish", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("overflow_flag", 32'(bus.overflow_flag), 32'(e.ovf));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_fin = bus.finish;
  end

  // One operation: start high for 9 edges (accept + 8 steps), operands scrambled while busy.
  // With keep set, start stays high so the next call is accepted straight from DONE.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    exp_t e;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e     = model(a, b);
    e.cyc = cyc + 8;
    sb.push_back(e);
    if (have_prev) begin
      check("finish_fall", 32'(bus.finish), 32'd0);
      check("result_hold", 32'(bus.result), 32'(last_res));
      check("ovf_hold", 32'(bus.overflow_flag), 32'(last_ovf));
    end
    last_res  = e.res;
    last_ovf  = e.ovf;
    have_prev = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.A = W'($urandom);
      bus.B = W'($urandom);
    end
    if (!keep) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [4];
    corners[0] = 16'h8000;
    corners[1] = 16'h7FFF;
    corners[2] = 16'h0000;
    corners[3] = 16'hFFFF;
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    bus.A     = '0;
    bus.B     = '0;
    bus.start = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_ovf", 32'(bus.overflow_flag), 32'd0);
    check("reset_finish", 32'(bus.finish), 32'd0);
    rst = 1'b0;

    op(16'h0400, 16'h0400, 0);
    op(16'h0200, 16'h0200, 0);
    op(16'h0C00, 16'hF800, 0);
    op(16'hFFFF, 16'h0001, 0);
    op(16'h0001, 16'h0001, 0);
    op(16'h7FFF, 16'h7FFF, 0);
    op(16'h8000, 16'h8000, 0);

    // Start held continuously: relaunch from DONE picks up the new operands.
    op(16'h1234, 16'hF00D, 1);
    op(16'hC000, 16'h0C00, 0);

    // Abort mid-operation: outputs clear and no completion follows.
    @(negedge clk);
    bus.A     = 16'h0300;
    bus.B     = 16'h0500;
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_ovf", 32'(bus.overflow_flag), 32'd0);
    check("abort_finish", 32'(bus.finish), 32'd0);
    rst       = 1'b0;
    have_prev = 0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 100; i++) begin
      op(pick(), pick(), 0);
    end

    for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
